// File: rtl/ip_codma_bus_arbiter_if.sv
// Bus bundle between the codma requesters and the shared memory-port arbiter.
interface ip_codma_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req_i;
  logic [4*NUM_REQ-1:0] size_i;
  logic                 beat_valid_i;
  logic                 bus_error_i;
  logic                 abort_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 bus_req_o;
  logic [3:0]           bus_size_o;
  logic [OWNER_W-1:0]   owner_o;
  logic                 busy_o;
  logic [NUM_REQ-1:0]   err_o;

  modport master (
    output req_i, size_i, beat_valid_i, bus_error_i, abort_i,
    input  grant_o, bus_req_o, bus_size_o, owner_o, busy_o, err_o
  );

  modport slave (
    input  req_i, size_i, beat_valid_i, bus_error_i, abort_i,
    output grant_o, bus_req_o, bus_size_o, owner_o, busy_o, err_o
  );
endinterface

// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin arbiter for the single codma memory port; holds the grant for a
// whole burst and releases on last beat, bus error or abort.
module ip_codma_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  ip_codma_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  arb_state_t           state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   rr_q, rr_d;
  logic [3:0]           size_q, size_d;
  logic [2:0]           last_q, last_d;   // beat target minus one
  logic [2:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   err_q, err_d;

  logic                 found;
  int unsigned          scan_idx;
  int unsigned          win_idx;
  logic [3:0]           win_size;
  logic                 size_ok;
  logic [2:0]           win_last;
  logic [NUM_REQ-1:0]   grant_vec;

  // Rotating scan starting at the round-robin pointer.
  always_comb begin
    found    = 1'b0;
    win_idx  = 0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_q) + i) % NUM_REQ;
      if (!found && bus.req_i[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    win_size = bus.size_i[4*win_idx +: 4];
    size_ok  = 1'b1;
    win_last = 3'd0;
    case (win_size)
      4'd3:    win_last = 3'd0;
      4'd8:    win_last = 3'd2;
      4'd9:    win_last = 3'd3;
      default: size_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    size_d  = size_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (found && !bus.abort_i) begin
          rr_d = OWNER_W'((win_idx + 1) % NUM_REQ);
          if (size_ok) begin
            owner_d = OWNER_W'(win_idx);
            size_d  = win_size;
            last_d  = win_last;
            cnt_d   = '0;
            state_d = ARB_BUSY;
          end else begin
            err_d[win_idx] = 1'b1;
          end
        end
      end
      ARB_BUSY: begin
        // Error/abort outrank a coincident last beat.
        if (bus.bus_error_i || bus.abort_i) begin
          state_d = ARB_RELEASE;
          if (bus.bus_error_i) err_d[owner_q] = 1'b1;
        end else if (bus.beat_valid_i) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == last_q) state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      size_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      size_q  <= size_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    grant_vec = '0;
    if (state_q == ARB_BUSY) grant_vec[owner_q] = 1'b1;
  end

  assign bus.grant_o    = grant_vec;
  assign bus.bus_req_o  = (state_q == ARB_BUSY);
  assign bus.bus_size_o = size_q;
  assign bus.owner_o    = owner_q;
  assign bus.busy_o     = (state_q != ARB_IDLE);
  assign bus.err_o      = err_q;

endmodule

// File: doc/ip_codma_bus_arbiter.md
# ip_codma_bus_arbiter

Shares the single codma memory port between the read machine, the write machine and any other bus masters in the codma datapath. The arbiter picks one requester at a time with round-robin priority and holds its grant until the whole burst completes, the bus reports an error, or the DMA aborts. It also forwards the owner's transfer size to the memory side and counts beats.

## Interface
- NUM_REQ, 2, number of requesters; index 0 = read machine, 1 = write machine.
- OWNER_W, max(1,$clog2(NUM_REQ)), width of the owner index.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester bus request; held high until granted.
- size_i  in  4*NUM_REQ  per-requester size code, slice [4*i+3:4*i]; 3 = 1 beat, 8 = 3 beats, 9 = 4 beats (64-bit beats).
- beat_valid_i  in  1  memory accepted or returned one 64-bit beat this cycle.
- bus_error_i  in  1  memory error.
- abort_i  in  1  DMA stop or error; terminates any transfer.
- grant_o  out  NUM_REQ  one-hot grant to the current owner.
- bus_req_o  out  1  request to memory; high for the whole burst.
- bus_size_o  out  4  latched size code of the owner.
- owner_o  out  OWNER_W  index of the current or last owner.
- busy_o  out  1  high in ARB_BUSY and ARB_RELEASE.
- err_o  out  NUM_REQ  one-cycle error pulse to the affected requester.

## Operation
- **Reset values:** state ARB_IDLE. grant_o, bus_req_o, bus_size_o, owner_o, busy_o, err_o, beat counter and round-robin pointer are all 0.
- **ARB_IDLE:**
  - Scan req_i starting at pointer rr_ptr and wrapping modulo NUM_REQ; the first set bit wins.
  - Valid size code: latch owner, size and beat target (1, 3 or 4). Clear the beat counter. Set rr_ptr = (winner+1) mod NUM_REQ. Go to ARB_BUSY.
  - Invalid size code (anything other than 3, 8 or 9): no grant. Pulse err_o[winner] for one cycle. rr_ptr advances past the winner. Stay in ARB_IDLE.
  - No request: stay in ARB_IDLE.
- **ARB_BUSY:**
  - grant_o[owner] = 1, bus_req_o = 1, bus_size_o = latched size.
  - Each beat_valid_i increments the beat counter (3-bit, no wrap possible since the maximum is 4).
  - Last beat (counter == target-1 with beat_valid_i): go to ARB_RELEASE.
- **ARB_RELEASE:** all grants low, bus_req_o low, busy_o high for one cycle, then go to ARB_IDLE.
- **Error or abort:** bus_error_i or abort_i in ARB_BUSY sends the arbiter to ARB_RELEASE on the next edge. bus_error_i also pulses err_o[owner]; abort_i alone does not. Both simultaneous: one err_o pulse. abort_i in ARB_IDLE blocks any new grant that cycle.
- **Simultaneous events:** last beat together with bus_error_i is treated as an error (err_o pulses). beat_valid_i outside ARB_BUSY is ignored.
- **Owner drops req_i mid-burst:** ignored; the burst continues to completion or abort.
- **Request changes:** size_i and req_i changes of the owner after the grant have no effect.

## Timing
- Registered outputs; no combinational path from inputs to grant_o or bus_req_o.
- req_i sampled at edge k in ARB_IDLE: grant_o and bus_req_o are high from cycle k+1.
- Last beat sampled at edge m: grant_o is low from cycle m+1 (ARB_RELEASE) and the arbiter is in ARB_IDLE at m+2. The earliest next grant is visible at m+3.
- A 4-beat burst with back-to-back beats occupies 6 cycles from grant to the next ARB_IDLE.
- err_o pulses in the cycle after the triggering edge and lasts exactly one cycle.
- Reset asserted mid-burst: all outputs go to 0 immediately (asynchronous); the first grant after release is re-arbitrated from rr_ptr = 0.

## Test plan
- **Single read:** req_i=01, size 9, four beats on consecutive cycles -> grant_o=01 for 4 cycles, bus_size_o=9, one cycle of ARB_RELEASE, then idle.
- **Contention:** req_i=11 held, both size 8 -> grant order 0,1,0,1. Each grant lasts exactly 3 beats, separated by a 1-cycle release gap.
- **Bus error:** bus_error_i on the 2nd beat of a size-9 burst owned by requester 1 -> err_o=10 for one cycle, grant drops the next cycle, requester 0 is granted next if pending.
- **Abort:** abort_i mid-burst -> grant and bus_req_o low the next cycle, err_o stays 0, no grant while abort_i is held.
- **Invalid size:** size_i=5 on requester 0 -> no grant, err_o=01 pulse, requester 1 with size 3 is granted on the following arbitration.
- **Asynchronous reset:** reset_n_i low mid-burst -> all outputs 0 within the same cycle; after release, req_i=10 -> grant_o=10 at k+1.
